// File: rtl/tridiag_det_sched.sv
// Round-robin front end for one shared tridiagonal-determinant engine: grants one
// requester at a time, holds its operands on the engine buses and returns the tagged result.
module tridiag_det_sched #(
  parameter int N     = 16,
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  localparam int IW   = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ*WIDTH*(N-1)-1:0] req_a_flat,
  input  logic [NREQ*WIDTH*N-1:0]     req_b_flat,
  input  logic [NREQ*WIDTH*(N-1)-1:0] req_c_flat,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [IW-1:0]               rsp_id,
  output logic [2*WIDTH-1:0]          rsp_det,
  output logic                        busy,
  output logic [15:0]                 jobs_done,
  output logic                        eng_start,
  output logic                        eng_ack,
  output logic [WIDTH*(N-1)-1:0]      eng_a_flat,
  output logic [WIDTH*N-1:0]          eng_b_flat,
  output logic [WIDTH*(N-1)-1:0]      eng_c_flat,
  input  logic                        eng_done,
  input  logic [2*WIDTH-1:0]          eng_det
);

  localparam int AW = WIDTH * (N - 1);
  localparam int BW = WIDTH * N;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_ACK, S_DRAIN
  } state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] ptr;
  logic [IW-1:0] grant;
  logic          grant_vld;
  logic          accept;
  logic          rsp_fire;
  logic          start_nxt, ack_nxt, rv_nxt, busy_nxt;

  // Offset a requester index from the round-robin pointer, wrapping at NREQ.
  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  // Scan downward so the requester closest to ptr is the one left standing.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[rr_idx(ptr, i)]) begin
        grant     = rr_idx(ptr, i);
        grant_vld = 1'b1;
      end
    end
  end

  // Handshakes: a transfer happens on a cycle where valid and ready are both high.
  // Requesters hold valid/operands until their ready strobe; the response holds
  // id/det stable while rsp_valid is high and rsp_ready is low.
  assign accept   = (state == S_IDLE) && grant_vld && !rst;
  assign rsp_fire = rsp_valid && rsp_ready;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      eng_start <= 1'b0;
      eng_ack   <= 1'b0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      eng_start <= start_nxt;
      eng_ack   <= ack_nxt;
      rsp_valid <= rv_nxt;
      busy      <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant_vld) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (eng_done) state_nxt = S_RESP;
      S_RESP:  if (rsp_fire) state_nxt = S_ACK;
      S_ACK:   state_nxt = S_DRAIN;
      S_DRAIN: if (!eng_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control outputs are decoded from the next state and registered, so each is
  // a clean pulse/level aligned with the state it belongs to.
  always_comb begin
    start_nxt = (state_nxt == S_ISSUE);
    ack_nxt   = (state_nxt == S_ACK);
    rv_nxt    = (state_nxt == S_RESP);
    busy_nxt  = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= '0;
      rsp_id     <= '0;
      rsp_det    <= '0;
      jobs_done  <= '0;
      eng_a_flat <= '0;
      eng_b_flat <= '0;
      eng_c_flat <= '0;
    end else begin
      if (accept) begin
        eng_a_flat <= req_a_flat[grant*AW +: AW];
        eng_b_flat <= req_b_flat[grant*BW +: BW];
        eng_c_flat <= req_c_flat[grant*AW +: AW];
        rsp_id     <= grant;
        ptr        <= (grant == IW'(NREQ - 1)) ? '0 : grant + 1'b1;
      end
      if (state == S_WAIT && eng_done) rsp_det <= eng_det;
      if (rsp_fire) jobs_done <= jobs_done + 16'd1;
    end
  end

endmodule
